// File: rtl/busy_dispatch_pkg.sv
// Shared types for the busy-counter job dispatcher.
//
// The dispatcher FSM has three states:
//   ST_IDLE   - no job in flight; fires a start when a job is queued and the counter is idle
//   ST_RUN    - job handed to the counter; waits for its busy flag to be low
//   ST_REPORT - presents the finished job's tag until the consumer takes it
package busy_dispatch_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } dispatch_state_e;

    // Width of an occupancy count that can hold 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/busy_job_dispatcher_fifo.sv
// job_tag_fifo: circular tag buffer with wrap-around pointers and an
// occupancy register.
//
// Ports:
//   CLK, nRST   clock, synchronous active-low reset (empties the buffer)
//   push_i      write din_i at the tail; ignored while full_o
//   pop_i       drop the head entry; ignored while empty_o
//   din_i       tag to write
//   dout_o      head entry (valid while !empty_o)
//   full_o      level_o == DEPTH
//   empty_o     level_o == 0
//   level_o     occupancy, 0..DEPTH
//
// No bypass: a tag pushed on an edge is visible at dout_o only after that edge.
module job_tag_fifo
    import busy_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = level_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [TAG_W-1:0] din_i,
    output logic [TAG_W-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == LVL_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Push and pop together leave the level unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/busy_job_dispatcher.sv
// busy_job_dispatcher: queues tagged jobs, runs them one at a time on the
// busy counter, and reports each finished tag downstream.
//
// Handshake semantics (all ports): a transfer happens on a rising CLK edge
// where X__ENA=1 and X__RDY=1. The initiator may only raise __ENA when the
// matching __RDY is 1 (enq, start), or holds __ENA and its payload stable
// until __RDY is seen (done).
//
// Ports:
//   CLK, nRST     clock, synchronous active-low reset
//   enq__ENA/RDY  job push; RDY = FIFO not full;  enq_tag = job tag
//   start__ENA    start pulse to the counter (combinational, IDLE only)
//   start__RDY    counter idle
//   ctr_busy      counter running (registered inside the counter)
//   done__ENA/RDY completion handshake; done_tag = finished job's tag
//   q_level       FIFO occupancy 0..DEPTH
//   jobs_done     completions accepted, wraps modulo 2^CNT_W
//   dbg_state_o   current FSM state, for observation only
module busy_job_dispatcher
    import busy_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16,
    localparam int LVL_W = level_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq__ENA,
    output logic             enq__RDY,
    input  logic [TAG_W-1:0] enq_tag,
    output logic             start__ENA,
    input  logic             start__RDY,
    input  logic             ctr_busy,
    output logic             done__ENA,
    input  logic             done__RDY,
    output logic [TAG_W-1:0] done_tag,
    output logic [LVL_W-1:0] q_level,
    output logic [CNT_W-1:0] jobs_done,
    output dispatch_state_e  dbg_state_o
);

    dispatch_state_e  state_q, state_d;
    logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
    logic [CNT_W-1:0] jobs_done_q, jobs_done_d;

    logic             fifo_pop;
    logic [TAG_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    job_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .CLK     (CLK),
        .nRST    (nRST),
        .push_i  (enq__ENA),
        .pop_i   (fifo_pop),
        .din_i   (enq_tag),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (q_level)
    );

    assign enq__RDY    = !fifo_full;
    assign done_tag    = cur_tag_q;
    assign jobs_done   = jobs_done_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d     = state_q;
        cur_tag_d   = cur_tag_q;
        jobs_done_d = jobs_done_q;
        start__ENA  = 1'b0;
        done__ENA   = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The start pulse and the FIFO pop are the same event.
                if (!fifo_empty && start__RDY) begin
                    start__ENA = 1'b1;
                    fifo_pop   = 1'b1;
                    cur_tag_d  = fifo_dout;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // Busy is already valid in the first RUN cycle; a one-step
                // counter never raises it, so low here means finished.
                if (!ctr_busy) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                done__ENA = 1'b1;
                if (done__RDY) begin
                    jobs_done_d = jobs_done_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            cur_tag_q   <= '0;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_tag_q   <= cur_tag_d;
            jobs_done_q <= jobs_done_d;
        end
    end

`ifdef FORMAL
    always_ff @(posedge CLK) begin
        if (nRST) begin
            assert (q_level <= LVL_W'(DEPTH));
            assert (!start__ENA || (state_q == ST_IDLE && start__RDY));
            assert (!(enq__ENA && !enq__RDY));
            if ($past(nRST) && $past(done__ENA) && !$past(done__RDY)) begin
                assert (done__ENA && done_tag == $past(done_tag));
            end
        end
    end
`endif

endmodule
